// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a short song stored as per-step half-period values.
//
// Each step lasts STEP_CYC clock cycles. The last GAP_CYC cycles of every
// step are muted so that repeated notes stay distinct.
//
// Parameters:
//   N_STEPS  - number of song-memory entries
//   DIV_W    - width of a stored half-period, in clk cycles (0 = rest)
//   STEP_CYC - clk cycles per song step
//   GAP_CYC  - muted cycles at the end of each step
//   STEP_W   - derived step index width; leave at its default
//
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   start          - begin playback from step 0 (only acted on when idle)
//   stop           - abort playback; overrides every other control
//   pause          - level-sensitive hold while playing
//   loop_en        - wrap from the last step back to step 0
//   last_idx       - final step index, latched on start
//   wr_en/addr/data- song-memory write port (only honoured when idle)
//   tone           - square-wave audio output
//   step           - index of the step currently playing
//   busy           - high while playing or paused
//   done           - one-cycle pulse when the song ends naturally
module tone_sequencer #(
    parameter int unsigned N_STEPS  = 8,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned STEP_CYC = 16,
    parameter int unsigned GAP_CYC  = 2,
    parameter int unsigned STEP_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [STEP_W-1:0] last_idx,
    input  logic              wr_en,
    input  logic [STEP_W-1:0] wr_addr,
    input  logic [DIV_W-1:0]  wr_data,
    output logic              tone,
    output logic [STEP_W-1:0] step,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TICK_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int unsigned TONE_END = STEP_CYC - GAP_CYC;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StPause
    } state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   last_q, last_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DIV_W-1:0]    phase_q, phase_d;
    logic                raw_q, raw_d;
    logic                done_q, done_d;

    // Song storage: deliberately not reset so a program survives rst_n.
    logic [DIV_W-1:0]    mem_q [N_STEPS];

    logic [DIV_W-1:0]    hp;
    logic                step_end;
    logic [STEP_W-1:0]   last_clamped;

    assign hp           = mem_q[step_q];
    assign step_end     = (tick_q == TICK_W'(STEP_CYC - 1));
    assign last_clamped = (32'(last_idx) >= N_STEPS) ? STEP_W'(N_STEPS - 1) : last_idx;

    always_ff @(posedge clk) begin
        if (wr_en && (state_q == StIdle) && (32'(wr_addr) < N_STEPS)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        last_d  = last_q;
        tick_d  = tick_q;
        phase_d = phase_q;
        raw_d   = raw_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPlay;
                    step_d  = '0;
                    tick_d  = '0;
                    phase_d = '0;
                    raw_d   = 1'b0;
                    last_d  = last_clamped;
                end
            end

            StPlay: begin
                // Square-wave divider for the current step's half-period.
                if (hp == '0) begin
                    phase_d = '0;
                    raw_d   = 1'b0;
                end else if (phase_q == hp - DIV_W'(1)) begin
                    phase_d = '0;
                    raw_d   = ~raw_q;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end

                if (step_end) begin
                    // Every new step starts its waveform from a clean phase.
                    tick_d  = '0;
                    phase_d = '0;
                    raw_d   = 1'b0;
                    if (step_q == last_q) begin
                        step_d = '0;
                        if (!loop_en) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end

                // The natural end of the song wins over entering pause.
                if ((state_d == StPlay) && pause) begin
                    state_d = StPause;
                end
            end

            StPause: begin
                if (!pause) begin
                    state_d = StPlay;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (stop) begin
            state_d = StIdle;
            step_d  = '0;
            tick_d  = '0;
            phase_d = '0;
            raw_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            last_q  <= '0;
            tick_q  <= '0;
            phase_q <= '0;
            raw_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            last_q  <= last_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            raw_q   <= raw_d;
            done_q  <= done_d;
        end
    end

    // Outputs derive only from registered state, so reset clears them at once.
    assign tone = raw_q && (state_q == StPlay) && (32'(tick_q) < TONE_END);
    assign step = step_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

    localparam int N_STEPS  = 8;
    localparam int DIV_W    = 8;
    localparam int STEP_CYC = 16;
    localparam int GAP_CYC  = 2;
    localparam int STEP_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic              loop_en = 1'b0;
    logic [STEP_W-1:0] last_idx = '0;
    logic              wr_en = 1'b0;
    logic [STEP_W-1:0] wr_addr = '0;
    logic [DIV_W-1:0]  wr_data = '0;
    logic              tone;
    logic [STEP_W-1:0] step;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    // Bench's own picture of the song memory.
    int mem_m [N_STEPS];

    tone_sequencer #(
        .N_STEPS  (N_STEPS),
        .DIV_W    (DIV_W),
        .STEP_CYC (STEP_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .loop_en  (loop_en),
        .last_idx (last_idx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .tone     (tone),
        .step     (step),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: k = number of PLAY cycles already elapsed in this playback.
    function automatic int exp_step(int k, int last, bit lp);
        int s;
        s = k / STEP_CYC;
        return lp ? (s % (last + 1)) : s;
    endfunction

    function automatic bit exp_tone(int k, int last, bit lp);
        int t;
        int hp;
        t  = k % STEP_CYC;
        hp = mem_m[exp_step(k, last, lp)];
        if (hp == 0 || t >= STEP_CYC - GAP_CYC) return 1'b0;
        return ((t / hp) % 2) == 1;
    endfunction

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(int a, int d);
        wr_en   = 1'b1;
        wr_addr = STEP_W'(a);
        wr_data = DIV_W'(d);
        cyc();
        wr_en   = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic begin_play(int last, bit lp);
        last_idx = STEP_W'(last);
        loop_en  = lp;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic end_play();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tone, busy, done, step} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: tone/busy/done/step=%b want 000000",
                     {tone, busy, done, step});
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++;
        if (busy !== 1'b0 || step !== '0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b step=%0d want 0/0", busy, step);
        end
        for (int a = 0; a < N_STEPS; a++) write_mem(a, 0);
    endtask

    task automatic test_single();
        write_mem(0, 2);
        write_mem(1, 0);
        begin_play(1, 1'b0);
        for (int c = 0; c < 40; c++) begin
            n_cmp++;
            if (c < 32) begin
                if (tone !== exp_tone(c, 1, 0) || step !== STEP_W'(exp_step(c, 1, 0)) ||
                    busy !== 1'b1 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_play c=%0d: tone=%b step=%0d busy=%b done=%b want %b %0d 1 0",
                             c, tone, step, busy, done, exp_tone(c, 1, 0), exp_step(c, 1, 0));
                end
            end else begin
                if (done !== (c == 32) || busy !== 1'b0 || tone !== 1'b0 || step !== '0) begin
                    n_err++;
                    $display("FAIL single_end c=%0d: done=%b busy=%b tone=%b step=%0d want %b 0 0 0",
                             c, done, busy, tone, step, (c == 32));
                end
            end
            cyc();
        end
    endtask

    task automatic test_loop();
        begin_play(1, 1'b1);
        for (int c = 0; c < 80; c++) begin
            n_cmp++;
            if (tone !== exp_tone(c, 1, 1) || step !== STEP_W'(exp_step(c, 1, 1)) ||
                busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL loop_play c=%0d: tone=%b step=%0d busy=%b done=%b want %b %0d 1 0",
                         c, tone, step, busy, done, exp_tone(c, 1, 1), exp_step(c, 1, 1));
            end
            cyc();
        end
        end_play();
        loop_en = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || tone !== 1'b0 || step !== '0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL loop_stop: busy=%b tone=%b step=%0d done=%b want 0 0 0 0",
                     busy, tone, step, done);
        end
    endtask

    task automatic test_pause();
        int  k;
        bit  paused;
        k      = 0;
        paused = 1'b0;
        begin_play(1, 1'b0);
        for (int c = 0; c < 30; c++) begin
            n_cmp++;
            if (paused) begin
                if (tone !== 1'b0 || busy !== 1'b1 || step !== STEP_W'(exp_step(k, 1, 0))) begin
                    n_err++;
                    $display("FAIL pause_hold c=%0d: tone=%b busy=%b step=%0d want 0 1 %0d",
                             c, tone, busy, step, exp_step(k, 1, 0));
                end
            end else begin
                if (tone !== exp_tone(k, 1, 0) || step !== STEP_W'(exp_step(k, 1, 0))) begin
                    n_err++;
                    $display("FAIL pause_play c=%0d: tone=%b step=%0d want %b %0d",
                             c, tone, step, exp_tone(k, 1, 0), exp_step(k, 1, 0));
                end
                k++;
            end
            if (c == 20 || c == 21) begin
                n_cmp++;
                if (step !== STEP_W'(c - 20)) begin
                    n_err++;
                    $display("FAIL pause_advance c=%0d: step=%0d want %0d", c, step, c - 20);
                end
            end
            pause  = (c >= 7 && c <= 11);
            paused = pause;
            cyc();
        end
        pause = 1'b0;
        end_play();
    endtask

    task automatic test_write_in_play();
        begin_play(1, 1'b0);
        cyc();
        cyc();
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'd5;
        cyc();
        wr_en   = 1'b0;
        cyc();
        end_play();
        begin_play(1, 1'b0);
        for (int c = 0; c < 16; c++) begin
            n_cmp++;
            if (tone !== exp_tone(c, 1, 0)) begin
                n_err++;
                $display("FAIL write_ignored c=%0d: tone=%b want %b", c, tone, exp_tone(c, 1, 0));
            end
            cyc();
        end
        end_play();
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (busy !== 1'b0 || tone !== 1'b0) begin
                n_err++;
                $display("FAIL start_stop c=%0d: busy=%b tone=%b want 0 0", c, busy, tone);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        write_mem(1, 3);
        begin_play(1, 1'b0);
        for (int c = 0; c < 20; c++) cyc();
        n_cmp++;
        if (tone !== exp_tone(20, 1, 0) || step !== 3'd1) begin
            n_err++;
            $display("FAIL reset_mid_pre: tone=%b step=%0d want %b 1",
                     tone, step, exp_tone(20, 1, 0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tone !== 1'b0 || busy !== 1'b0 || step !== '0) begin
            n_err++;
            $display("FAIL reset_mid_async: tone=%b busy=%b step=%0d want 0 0 0", tone, busy, step);
        end
        cyc();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy !== 1'b0) saw_done = 1'b1;
            cyc();
        end
        n_cmp++;
        if (saw_done) begin
            n_err++;
            $display("FAIL reset_mid_idle: saw done or busy after reset, want neither");
        end
        begin_play(1, 1'b0);
        for (int c = 0; c < 32; c++) begin
            n_cmp++;
            if (tone !== exp_tone(c, 1, 0) || step !== STEP_W'(exp_step(c, 1, 0))) begin
                n_err++;
                $display("FAIL reset_mem_kept c=%0d: tone=%b step=%0d want %b %0d",
                         c, tone, step, exp_tone(c, 1, 0), exp_step(c, 1, 0));
            end
            cyc();
        end
        cyc();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int  last;
            int  k;
            int  total;
            bit  paused;
            bit  ended;
            last   = $urandom_range(0, N_STEPS - 1);
            total  = (last + 1) * STEP_CYC;
            k      = 0;
            paused = 1'b0;
            ended  = 1'b0;
            for (int a = 0; a < N_STEPS; a++) write_mem(a, $urandom_range(0, 6));
            begin_play(last, 1'b0);
            for (int c = 0; c < 600 && !ended; c++) begin
                n_cmp++;
                if (k == total) begin
                    ended = 1'b1;
                    if (done !== 1'b1 || busy !== 1'b0 || tone !== 1'b0) begin
                        n_err++;
                        $display("FAIL rand_end it=%0d: done=%b busy=%b tone=%b want 1 0 0",
                                 it, done, busy, tone);
                    end
                end else if (paused) begin
                    if (tone !== 1'b0 || busy !== 1'b1 || done !== 1'b0 ||
                        step !== STEP_W'(exp_step(k, last, 0))) begin
                        n_err++;
                        $display("FAIL rand_pause it=%0d c=%0d: tone=%b busy=%b step=%0d want 0 1 %0d",
                                 it, c, tone, busy, step, exp_step(k, last, 0));
                    end
                end else begin
                    if (tone !== exp_tone(k, last, 0) || busy !== 1'b1 || done !== 1'b0 ||
                        step !== STEP_W'(exp_step(k, last, 0))) begin
                        n_err++;
                        $display("FAIL rand_play it=%0d c=%0d: tone=%b step=%0d busy=%b want %b %0d 1",
                                 it, c, tone, step, busy, exp_tone(k, last, 0),
                                 exp_step(k, last, 0));
                    end
                    k++;
                end
                pause  = !ended && ($urandom_range(0, 3) == 0);
                paused = pause;
                cyc();
            end
            pause = 1'b0;
            if (!ended) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand_timeout it=%0d: no song end within budget", it);
                end_play();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loop();
        test_pause();
        test_write_in_play();
        test_start_stop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
